// File: rtl/semaphore_pkg.sv
// semaphore_pkg: state encodings, default dwell times, width helpers
// shared by traffic_semaphore_fsm and semaphore_timer.
package semaphore_pkg;

  localparam logic [3:0] OFF    = 4'b0001;
  localparam logic [3:0] RED    = 4'b0010;
  localparam logic [3:0] YELLOW = 4'b0100;
  localparam logic [3:0] GREEN  = 4'b1000;

  localparam int DEF_RED_CYCLES    = 51;
  localparam int DEF_YELLOW_CYCLES = 11;
  localparam int DEF_GREEN_CYCLES  = 20;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width; kept at 1 bit when every phase is one cycle.
  function automatic int cnt_w(int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  // Width able to hold the limit value itself.
  function automatic int lim_w(int m);
    return (m <= 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/semaphore_timer.sv
// semaphore_timer: dwell counter, cleared by clear, else counts up.
// Ports: clk, clear, limit[LW] in; done out (count == limit-1).
module semaphore_timer
  import semaphore_pkg::*;
#(
  parameter int MAX_CYCLES = DEF_RED_CYCLES
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic [lim_w(MAX_CYCLES)-1:0] limit,
  output logic                         done
);

  localparam int CW = cnt_w(MAX_CYCLES);
  localparam int LW = lim_w(MAX_CYCLES);

  logic [CW-1:0] r_cnt;

  // No wrap guard: the owner always clears on done.
  always_ff @(posedge clk) begin
    if (clear) r_cnt <= '0;
    else       r_cnt <= r_cnt + 1'b1;
  end

  assign done = (LW'(r_cnt) == (limit - 1'b1));

endmodule

// File: rtl/traffic_semaphore_fsm.sv
// traffic_semaphore_fsm: RED->YELLOW->GREEN cycler, dark when !enable.
// Ports: clk, rst, enable in; red, yellow, green, state_out[4] out.
module traffic_semaphore_fsm
  import semaphore_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [3:0] state_out
);

  localparam int MAXC =
    max3(RED_CYCLES, YELLOW_CYCLES, GREEN_CYCLES);
  localparam int LW = lim_w(MAXC);

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [LW-1:0] w_limit;
  logic          w_done;
  logic          w_clear;

  always_ff @(posedge clk) begin
    if (rst) r_state <= OFF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = OFF;
    if (enable) begin
      case (r_state)
        OFF:     w_next = RED;
        RED:     w_next = w_done ? YELLOW : RED;
        YELLOW:  w_next = w_done ? GREEN : YELLOW;
        GREEN:   w_next = w_done ? RED : GREEN;
        default: w_next = OFF;
      endcase
    end
  end

  always_comb begin
    red    = 1'b0;
    yellow = 1'b0;
    green  = 1'b0;
    case (r_state)
      RED:     red    = 1'b1;
      YELLOW:  yellow = 1'b1;
      GREEN:   green  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_limit = LW'(1);
    case (r_state)
      RED:     w_limit = LW'(RED_CYCLES);
      YELLOW:  w_limit = LW'(YELLOW_CYCLES);
      GREEN:   w_limit = LW'(GREEN_CYCLES);
      default: ;
    endcase
  end

  // Any state change (or reset) restarts the dwell count.
  assign w_clear = rst | (w_next != r_state);

  semaphore_timer #(
    .MAX_CYCLES(MAXC)
  ) u_timer (
    .clk  (clk),
    .clear(w_clear),
    .limit(w_limit),
    .done (w_done)
  );

  assign state_out = r_state;

endmodule

// File: tb/tb_traffic_semaphore_fsm.sv
// tb_traffic_semaphore_fsm: directed stimulus, per-cycle model compare
// plus literal phase-length and latency checks.
module tb_traffic_semaphore_fsm;

  localparam int RC = 51;
  localparam int YC = 11;
  localparam int GC = 20;
  localparam int PER = RC + YC + GC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       red, yellow, green;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  int m_t = -1;

  traffic_semaphore_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Model: cycles elapsed since entering RED, -1 when dark.
  always @(posedge clk) begin
    if (rst || !enable) m_t = -1;
    else                m_t = m_t + 1;
  end

  function automatic logic [3:0] exp_state(int t);
    int p;
    if (t < 0) return 4'b0001;
    p = t % PER;
    if (p < RC) return 4'b0010;
    if (p < RC + YC) return 4'b0100;
    return 4'b1000;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    if (checking) begin
      e = exp_state(m_t);
      checks++;
      if (state_out !== e || red !== e[1] ||
          yellow !== e[2] || green !== e[3]) begin
        errors++;
        $display("FAIL model t=%0d state=%b ryg=%b%b%b need %b",
                 m_t, state_out, red, yellow, green, e);
      end
      checks++;
      if (!$onehot(state_out) ||
          (int'(red) + int'(yellow) + int'(green)) > 1) begin
        errors++;
        $display("FAIL onehot state=%b ryg=%b%b%b need onehot",
                 state_out, red, yellow, green);
      end
    end
  end

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(string nm, logic [3:0] s);
    checks++;
    if (state_out !== s) begin
      errors++;
      $display("FAIL %s state=%b need %b", nm, state_out, s);
    end
  endtask

  task automatic wait_for(string nm, logic [3:0] s);
    int n;
    n = 0;
    while (state_out !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state_out !== s) begin
      errors++;
      $display("FAIL %s timeout state=%b need %b", nm, state_out, s);
    end
  endtask

  task automatic measure(string nm, logic [3:0] s, int len);
    int n;
    n = 0;
    while (state_out === s && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != len) begin
      errors++;
      $display("FAIL %s len=%0d need %0d", nm, n, len);
    end
  endtask

  initial begin
    @(negedge clk);
    checking = 1'b1;
    chk("reset0", 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    cyc(10);
    chk("idle", 4'b0001);

    enable = 1'b1;
    @(negedge clk);
    chk("start_red", 4'b0010);
    for (int k = 0; k < 2; k++) begin
      measure("red_len", 4'b0010, RC);
      measure("yel_len", 4'b0100, YC);
      measure("grn_len", 4'b1000, GC);
    end
    chk("red_again", 4'b0010);

    wait_for("reach_yel", 4'b0100);
    cyc(3);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_yel", 4'b0001);
    checks++;
    if ({red, yellow, green} !== 3'b000) begin
      errors++;
      $display("FAIL dark_lamps ryg=%b%b%b need 000",
               red, yellow, green);
    end
    cyc(9);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_red", 4'b0010);
    measure("reen_red_len", 4'b0010, RC);

    wait_for("reach_grn", 4'b1000);
    cyc(GC - 1);
    chk("last_grn", 4'b1000);
    enable = 1'b0;
    @(negedge clk);
    chk("tc_dis", 4'b0001);

    enable = 1'b1;
    wait_for("reach_grn2", 4'b1000);
    cyc(5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_grn", 4'b0001);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_red", 4'b0010);
    measure("rst_red_len", 4'b0010, RC);

    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    @(negedge clk);
    chk("pulse_red", 4'b0010);
    enable = 1'b0;
    @(negedge clk);
    chk("pulse_off", 4'b0001);
    cyc(4);

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
